// File: rtl/max_result_reporter_pkg.sv
// ---------------------------------------------------------------------------
// max_result_reporter_pkg
//   Shared definitions for the max-result reporter: default field widths of
//   the best-score result, output beat width, header tag, the reporter state
//   encoding and the beats-per-field helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package max_result_reporter_pkg;

    localparam int DV_SCORE_WIDTH    = 10;
    localparam int DV_ROW_BITS_WIDTH = 6;
    localparam int DV_COL_BITS_WIDTH = 6;
    localparam int DV_OUT_WIDTH      = 8;

    localparam logic [7:0] DV_HDR_TAG = 8'hA5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        HDR     = 3'd2,
        SCORE   = 3'd3,
        ROW     = 3'd4,
        COL     = 3'd5
    } rpt_state_t;

    // Number of OUT_WIDTH beats needed to carry a field of the given width.
    function automatic int beats_for(input int field_w, input int out_w);
        return (field_w + out_w - 1) / out_w;
    endfunction

    localparam int DV_NS = beats_for(DV_SCORE_WIDTH, DV_OUT_WIDTH);
    localparam int DV_NR = beats_for(DV_ROW_BITS_WIDTH, DV_OUT_WIDTH);
    localparam int DV_NC = beats_for(DV_COL_BITS_WIDTH, DV_OUT_WIDTH);

endpackage

// File: rtl/max_result_reporter_field_chunk_sel.sv
// ---------------------------------------------------------------------------
// field_chunk_sel
//   Zero-extends a result field to N_CHUNKS*OUT_W bits and returns the
//   OUT_W-bit chunk selected by i_idx (chunk 0 = least significant).
//   Ports:
//     i_field  in  FIELD_W  field value (already captured in a shadow reg)
//     i_idx    in  IDX_W    chunk index
//     o_chunk  out OUT_W    selected chunk (zero when i_idx >= N_CHUNKS)
// ---------------------------------------------------------------------------
module field_chunk_sel
    import max_result_reporter_pkg::*;
#(
    parameter int FIELD_W  = DV_SCORE_WIDTH,
    parameter int N_CHUNKS = DV_NS,
    parameter int OUT_W    = DV_OUT_WIDTH,
    parameter int IDX_W    = 1
) (
    input  logic [FIELD_W-1:0] i_field,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [OUT_W-1:0]   o_chunk
);

    localparam int EXT_W = N_CHUNKS * OUT_W;

    logic [EXT_W-1:0] w_ext;

    assign w_ext   = EXT_W'(i_field);
    // Shifting past the top yields zero, so out-of-range indices are harmless.
    assign o_chunk = OUT_W'(w_ext >> (OUT_W * int'(i_idx)));

endmodule

// File: rtl/max_result_reporter.sv
// ---------------------------------------------------------------------------
// max_result_reporter
//   On a start pulse, captures the best score/row/col from the max-register
//   stage into shadow registers and streams a framed beat sequence:
//   header, score chunks, row chunks, col chunks (each field LSB chunk first).
//
//   Handshake: a beat transfers on a cycle where out_valid && out_ready.
//   Once out_valid is high, out_data/out_last hold until that transfer;
//   out_valid only falls after a transfer (or on rst). out_data is zero
//   whenever out_valid is low.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             1-cycle pulse: result is final
//     max_score/row/col result fields from the max-register stage
//     out_data/valid/last/ready  output beat stream
//     busy              frame in progress (CAPTURE .. last transfer)
//     done              1-cycle pulse after the final transfer
//     err_overrun       sticky: start arrived while busy or on the done cycle
//     o_dbg_state       current reporter state
// ---------------------------------------------------------------------------
module max_result_reporter
    import max_result_reporter_pkg::*;
#(
    parameter int         SCORE_WIDTH    = DV_SCORE_WIDTH,
    parameter int         ROW_BITS_WIDTH = DV_ROW_BITS_WIDTH,
    parameter int         COL_BITS_WIDTH = DV_COL_BITS_WIDTH,
    parameter int         OUT_WIDTH      = DV_OUT_WIDTH,
    parameter logic [7:0] HDR_TAG        = DV_HDR_TAG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SCORE_WIDTH-1:0]    max_score,
    input  logic [ROW_BITS_WIDTH-1:0] max_row,
    input  logic [COL_BITS_WIDTH-1:0] max_col,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err_overrun,
    output rpt_state_t                o_dbg_state
);

    localparam int NS   = beats_for(SCORE_WIDTH, OUT_WIDTH);
    localparam int NR   = beats_for(ROW_BITS_WIDTH, OUT_WIDTH);
    localparam int NC   = beats_for(COL_BITS_WIDTH, OUT_WIDTH);
    localparam int MAXN = (NS > NR) ? ((NS > NC) ? NS : NC) : ((NR > NC) ? NR : NC);
    localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

    rpt_state_t                r_state;
    logic [CW-1:0]             r_cnt;
    logic [SCORE_WIDTH-1:0]    r_score;
    logic [ROW_BITS_WIDTH-1:0] r_row;
    logic [COL_BITS_WIDTH-1:0] r_col;
    logic [OUT_WIDTH-1:0]      r_data;
    logic                      r_valid;
    logic                      r_last;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;

    logic [CW-1:0]        w_cnt_inc;
    logic [CW-1:0]        w_score_idx;
    logic [CW-1:0]        w_row_idx;
    logic [CW-1:0]        w_col_idx;
    logic [OUT_WIDTH-1:0] w_score_chunk;
    logic [OUT_WIDTH-1:0] w_row_chunk;
    logic [OUT_WIDTH-1:0] w_col_chunk;
    logic                 w_hs;
    logic                 w_start_ok;
    logic                 w_score_end;
    logic                 w_row_end;
    logic                 w_col_end;

    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_hs       = r_valid && out_ready;
    // The done cycle still counts as busy for start purposes.
    assign w_start_ok = start && (r_state == IDLE) && !r_done;

    assign w_score_end = (r_cnt == CW'(NS - 1));
    assign w_row_end   = (r_cnt == CW'(NR - 1));
    assign w_col_end   = (r_cnt == CW'(NC - 1));

    // Each selector looks one beat ahead: inside its own field it points at
    // the next chunk, elsewhere at chunk 0 (the first beat of that field).
    assign w_score_idx = (r_state == SCORE) ? w_cnt_inc : '0;
    assign w_row_idx   = (r_state == ROW)   ? w_cnt_inc : '0;
    assign w_col_idx   = (r_state == COL)   ? w_cnt_inc : '0;

    field_chunk_sel #(
        .FIELD_W (SCORE_WIDTH),
        .N_CHUNKS(NS),
        .OUT_W   (OUT_WIDTH),
        .IDX_W   (CW)
    ) u_score_sel (
        .i_field(r_score),
        .i_idx  (w_score_idx),
        .o_chunk(w_score_chunk)
    );

    field_chunk_sel #(
        .FIELD_W (ROW_BITS_WIDTH),
        .N_CHUNKS(NR),
        .OUT_W   (OUT_WIDTH),
        .IDX_W   (CW)
    ) u_row_sel (
        .i_field(r_row),
        .i_idx  (w_row_idx),
        .o_chunk(w_row_chunk)
    );

    field_chunk_sel #(
        .FIELD_W (COL_BITS_WIDTH),
        .N_CHUNKS(NC),
        .OUT_W   (OUT_WIDTH),
        .IDX_W   (CW)
    ) u_col_sel (
        .i_field(r_col),
        .i_idx  (w_col_idx),
        .o_chunk(w_col_chunk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_score <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start && !w_start_ok) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state <= CAPTURE;
                        r_busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_score <= max_score;
                    r_row   <= max_row;
                    r_col   <= max_col;
                    r_cnt   <= '0;
                    r_data  <= OUT_WIDTH'(HDR_TAG);
                    r_valid <= 1'b1;
                    r_last  <= 1'b0;
                    r_state <= HDR;
                end
                HDR: begin
                    if (w_hs) begin
                        r_state <= SCORE;
                        r_cnt   <= '0;
                        r_data  <= w_score_chunk;
                    end
                end
                SCORE: begin
                    if (w_hs) begin
                        if (w_score_end) begin
                            r_state <= ROW;
                            r_cnt   <= '0;
                            r_data  <= w_row_chunk;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_data <= w_score_chunk;
                        end
                    end
                end
                ROW: begin
                    if (w_hs) begin
                        if (w_row_end) begin
                            r_state <= COL;
                            r_cnt   <= '0;
                            r_data  <= w_col_chunk;
                            r_last  <= (NC == 1);
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_data <= w_row_chunk;
                        end
                    end
                end
                COL: begin
                    if (w_hs) begin
                        if (w_col_end) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_data  <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_data <= w_col_chunk;
                            r_last <= (w_cnt_inc == CW'(NC - 1));
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_data  <= '0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data    = r_data;
    assign out_valid   = r_valid;
    assign out_last    = r_last;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_overrun = r_err;
    assign o_dbg_state = r_state;

endmodule
